// File: rtl/queue_op_ctl_if.sv
// queue_op_ctl_if: request/response handshake bundle for queue_op_ctl.
// Ports: req_valid/req_op/req_ready (request), rsp_valid/rsp_ready/rsp_err/rsp_last (response).
interface queue_op_ctl_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_err;
   logic [31:0] rsp_last;

   modport master (
      output req_valid, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_err, rsp_last
   );

   modport slave (
      input  req_valid, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_err, rsp_last
   );
endinterface

// File: rtl/queue_op_ctl.sv
// queue_op_ctl: enq/deq controller driving an external last-address counter.
// Ports: clk, rst (async active-low), bus (slave: request/response handshake),
//        enq/deq/last_done strobes, last_addr out, new_last in, mismatch flag.
// Optional macro LAST_CHECK_EN adds the sticky counter-mismatch comparator.
module queue_op_ctl #(
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   queue_op_ctl_if.slave bus,
   output logic          enq,
   output logic          deq,
   output logic          last_done,
   output logic [31:0]   last_addr,
   input  logic [31:0]   new_last,
   output logic          mismatch
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   state_e      state_q;
   logic        rdy_q;
   logic        enq_q;
   logic        deq_q;
   logic        done_q;
   logic        vld_q;
   logic        err_q;
   logic        fresh_q;
   logic [31:0] last_q;
   logic [31:0] rsp_last_q;

   logic        accept_d;
   logic        can_enq_d;
   logic        can_deq_d;
   logic [31:0] rsp_last_d;

`ifdef LAST_CHECK_EN
   logic        is_enq_q;
   logic        mis_q;
   logic [31:0] exp_last_d;
`endif

   always_comb begin
      accept_d   = bus.req_valid & rdy_q;
      can_enq_d  = (bus.req_op == 2'b01) && (last_q < 32'(DEPTH));
      can_deq_d  = (bus.req_op == 2'b10) && (last_q != 32'd0);
      // new_last only becomes valid in the first RESP cycle, so it is
      // passed straight through then and held from a register afterwards.
      rsp_last_d = fresh_q ? new_last : rsp_last_q;
`ifdef LAST_CHECK_EN
      exp_last_d = is_enq_q ? last_q + 32'd1 : last_q - 32'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rdy_q      <= 1'b0;
         enq_q      <= 1'b0;
         deq_q      <= 1'b0;
         done_q     <= 1'b0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
         fresh_q    <= 1'b0;
         last_q     <= 32'd0;
         rsp_last_q <= 32'd0;
`ifdef LAST_CHECK_EN
         is_enq_q   <= 1'b0;
         mis_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               rdy_q <= 1'b1;
               if (accept_d) begin
                  rdy_q <= 1'b0;
                  if (can_enq_d || can_deq_d) begin
                     state_q  <= ISSUE;
                     enq_q    <= can_enq_d;
                     deq_q    <= can_deq_d;
                     done_q   <= 1'b1;
`ifdef LAST_CHECK_EN
                     is_enq_q <= can_enq_d;
`endif
                  end else begin
                     state_q    <= RESP;
                     vld_q      <= 1'b1;
                     err_q      <= 1'b1;
                     rsp_last_q <= last_q;
                  end
               end
            end
            ISSUE: begin
               enq_q   <= 1'b0;
               deq_q   <= 1'b0;
               done_q  <= 1'b0;
               vld_q   <= 1'b1;
               err_q   <= 1'b0;
               fresh_q <= 1'b1;
               state_q <= RESP;
            end
            RESP: begin
               fresh_q    <= 1'b0;
               rsp_last_q <= rsp_last_d;
`ifdef LAST_CHECK_EN
               if (fresh_q && (new_last != exp_last_d))
                  mis_q <= 1'b1;
`endif
               if (bus.rsp_ready) begin
                  vld_q   <= 1'b0;
                  err_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
                  if (!err_q)
                     last_q <= rsp_last_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = rdy_q;
   assign bus.rsp_valid = vld_q;
   assign bus.rsp_err   = err_q;
   assign bus.rsp_last  = rsp_last_d;
   assign enq           = enq_q;
   assign deq           = deq_q;
   assign last_done     = done_q;
   assign last_addr     = last_q;

`ifdef LAST_CHECK_EN
   assign mismatch = mis_q;
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_queue_op_ctl.sv
// tb_queue_op_ctl: randomized self-checking bench for queue_op_ctl.
// Includes a behavioural last-address counter and a queue-occupancy model.
module tb_queue_op_ctl;
   localparam int unsigned DEPTH = 16;
`ifdef LAST_CHECK_EN
   localparam bit MIS_EXP = 1'b1;
`else
   localparam bit MIS_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enq, deq, last_done, mismatch;
   logic [31:0] last_addr, new_last;
   logic [31:0] cnt_q = 32'd0;
   bit          bug = 1'b0;

   int          n_pass = 0;
   int          n_total = 0;
   int unsigned m_last = 0;

   queue_op_ctl_if bus();

   queue_op_ctl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .enq       (enq),
      .deq       (deq),
      .last_done (last_done),
      .last_addr (last_addr),
      .new_last  (new_last),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   // external last-address counter; bug makes enq step by 2
   always @(posedge clk)
      if (last_done)
         cnt_q <= enq ? last_addr + (bug ? 32'd2 : 32'd1) : last_addr - 32'd1;
   assign new_last = cnt_q;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      m_last = 0;
   endtask

   // runs one operation; returns what was observed, checks are done by callers
   task automatic do_op(input logic [1:0] op, input int hold,
                        output int lat, output bit err,
                        output logic [31:0] last, output logic [2:0] strb,
                        output bit hold_ok, output bit tmo);
      tmo = 1'b0; lat = 0; err = 1'b0; last = 32'd0; strb = 3'd0; hold_ok = 1'b0;
      for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
      if (bus.req_ready !== 1'b1) begin tmo = 1'b1; return; end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 2'($urandom_range(0, 3));
      strb = {enq, deq, last_done};
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (bus.rsp_valid !== 1'b1) begin
         tmo = 1'b1;
         bus.req_valid = 1'b0;
         return;
      end
      err = bus.rsp_err;
      last = bus.rsp_last;
      hold_ok = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== err ||
             bus.rsp_last !== last || bus.req_ready !== 1'b0 ||
             {enq, deq, last_done} !== 3'b000)
            hold_ok = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      if (bus.rsp_valid !== 1'b0) hold_ok = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.rsp_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({enq, deq, last_done} !== 3'b000)
         $display("FAIL rst_strobes: got %b want 000", {enq, deq, last_done});
      else n_pass++;
      n_total++;
      if (last_addr !== 32'd0) $display("FAIL rst_last_addr: got %0d want 0", last_addr);
      else n_pass++;
      n_total++;
      if ({bus.rsp_valid, bus.rsp_err, bus.req_ready, mismatch} !== 4'b0000)
         $display("FAIL rst_flags: got %b want 0000",
                  {bus.rsp_valid, bus.rsp_err, bus.req_ready, mismatch});
      else n_pass++;
      n_total++;
      if (bus.rsp_last !== 32'd0) $display("FAIL rst_rsp_last: got %0d want 0", bus.rsp_last);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", bus.req_ready);
      else n_pass++;
      m_last = 0;
   endtask

   task automatic test_enq3();
      int lat; bit err, hok, tmo; logic [31:0] last; logic [2:0] strb;
      for (int i = 1; i <= 3; i++) begin
         do_op(2'b01, 0, lat, err, last, strb, hok, tmo);
         m_last++;
         n_total++;
         if (tmo || lat != 2 || strb !== 3'b101)
            $display("FAIL enq3_timing: got tmo=%0d lat=%0d strb=%b want 0/2/101", tmo, lat, strb);
         else n_pass++;
         n_total++;
         if (err !== 1'b0 || last !== 32'(i))
            $display("FAIL enq3_rsp: got err=%0d last=%0d want 0/%0d", err, last, i);
         else n_pass++;
      end
      n_total++;
      if (last_addr !== 32'd3) $display("FAIL enq3_last_addr: got %0d want 3", last_addr);
      else n_pass++;
   endtask

   task automatic test_deq_empty();
      int lat; bit err, hok, tmo; logic [31:0] last; logic [2:0] strb;
      apply_reset();
      do_op(2'b10, 0, lat, err, last, strb, hok, tmo);
      n_total++;
      if (tmo || lat != 1 || strb !== 3'b000 || err !== 1'b1 || last !== 32'd0)
         $display("FAIL deq_empty: got tmo=%0d lat=%0d strb=%b err=%0d last=%0d want 0/1/000/1/0",
                  tmo, lat, strb, err, last);
      else n_pass++;
      n_total++;
      if (last_addr !== 32'd0) $display("FAIL deq_empty_addr: got %0d want 0", last_addr);
      else n_pass++;
   endtask

   task automatic test_full();
      int lat; bit err, hok, tmo, ok; logic [31:0] last; logic [2:0] strb;
      apply_reset();
      ok = 1'b1;
      for (int i = 1; i <= int'(DEPTH); i++) begin
         do_op(2'b01, 0, lat, err, last, strb, hok, tmo);
         if (tmo || err || last !== 32'(i) || lat != 2) ok = 1'b0;
      end
      m_last = DEPTH;
      n_total++;
      if (!ok || last_addr !== 32'(DEPTH))
         $display("FAIL full_fill: got ok=%0d last_addr=%0d want 1/%0d", ok, last_addr, DEPTH);
      else n_pass++;
      do_op(2'b01, 0, lat, err, last, strb, hok, tmo);
      n_total++;
      if (tmo || lat != 1 || strb !== 3'b000 || err !== 1'b1 || last !== 32'(DEPTH))
         $display("FAIL full_reject: got tmo=%0d lat=%0d strb=%b err=%0d last=%0d want 0/1/000/1/%0d",
                  tmo, lat, strb, err, last, DEPTH);
      else n_pass++;
      do_op(2'b10, 0, lat, err, last, strb, hok, tmo);
      m_last = DEPTH - 1;
      n_total++;
      if (tmo || lat != 2 || strb !== 3'b011 || err !== 1'b0 || last !== 32'(DEPTH - 1))
         $display("FAIL full_deq: got tmo=%0d lat=%0d strb=%b err=%0d last=%0d want 0/2/011/0/%0d",
                  tmo, lat, strb, err, last, DEPTH - 1);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int lat; bit err, hok, tmo; logic [31:0] last; logic [2:0] strb;
      do_op(2'b01, 5, lat, err, last, strb, hok, tmo);
      m_last++;
      n_total++;
      if (tmo || !hok) $display("FAIL bp_hold: got tmo=%0d hold_ok=%0d want 0/1", tmo, hok);
      else n_pass++;
      n_total++;
      if (last !== 32'(m_last) || last_addr !== 32'(m_last))
         $display("FAIL bp_value: got last=%0d addr=%0d want %0d", last, last_addr, m_last);
      else n_pass++;
   endtask

   task automatic test_reset_issue();
      bit seen;
      for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b10;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_total++;
      if (last_done !== 1'b1) $display("FAIL rsti_in_issue: got done=%b want 1", last_done);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({enq, deq, last_done, bus.rsp_valid, bus.rsp_err, bus.req_ready, mismatch} !== 7'd0 ||
          last_addr !== 32'd0 || bus.rsp_last !== 32'd0)
         $display("FAIL rsti_async: got flags=%b addr=%0d rsp_last=%0d want 0/0/0",
                  {enq, deq, last_done, bus.rsp_valid, bus.rsp_err, bus.req_ready, mismatch},
                  last_addr, bus.rsp_last);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || last_done !== 1'b0) seen = 1'b1;
      end
      m_last = 0;
      n_total++;
      if (seen || bus.req_ready !== 1'b1 || last_addr !== 32'd0)
         $display("FAIL rsti_after: got rsp_seen=%0d ready=%b addr=%0d want 0/1/0",
                  seen, bus.req_ready, last_addr);
      else n_pass++;
   endtask

   task automatic test_random();
      int lat, exp_lat, r, hold; bit err, hok, tmo, legal;
      logic [31:0] last; logic [2:0] strb, exp_strb; logic [1:0] op;
      int unsigned exp_last;
      apply_reset();
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
         hold = $urandom_range(0, 2);
         legal = (op == 2'b01 && m_last < DEPTH) || (op == 2'b10 && m_last > 0);
         exp_last = !legal ? m_last : (op == 2'b01) ? m_last + 1 : m_last - 1;
         exp_lat  = legal ? 2 : 1;
         exp_strb = !legal ? 3'b000 : (op == 2'b01) ? 3'b101 : 3'b011;
         do_op(op, hold, lat, err, last, strb, hok, tmo);
         n_total++;
         if (tmo || err !== !legal || last !== 32'(exp_last) || lat != exp_lat ||
             strb !== exp_strb || !hok)
            $display("FAIL rand_op%0d: op=%b got tmo=%0d err=%0d last=%0d lat=%0d strb=%b hold=%0d want err=%0d last=%0d lat=%0d strb=%b",
                     i, op, tmo, err, last, lat, strb, hok, !legal, exp_last, exp_lat, exp_strb);
         else n_pass++;
         m_last = exp_last;
      end
      n_total++;
      if (last_addr !== 32'(m_last))
         $display("FAIL rand_last_addr: got %0d want %0d", last_addr, m_last);
      else n_pass++;
   endtask

   task automatic test_mismatch();
      int lat; bit err, hok, tmo; logic [31:0] last; logic [2:0] strb;
      apply_reset();
      bug = 1'b1;
      do_op(2'b01, 0, lat, err, last, strb, hok, tmo);
      bug = 1'b0;
      m_last = 2;
      n_total++;
      if (tmo || err !== 1'b0 || last !== 32'd2)
         $display("FAIL mis_bad_rsp: got tmo=%0d err=%0d last=%0d want 0/0/2", tmo, err, last);
      else n_pass++;
      n_total++;
      if (mismatch !== MIS_EXP) $display("FAIL mis_set: got %b want %b", mismatch, MIS_EXP);
      else n_pass++;
      do_op(2'b01, 1, lat, err, last, strb, hok, tmo);
      do_op(2'b10, 0, lat, err, last, strb, hok, tmo);
      n_total++;
      if (tmo || last !== 32'd2 || last_addr !== 32'd2)
         $display("FAIL mis_later_ops: got tmo=%0d last=%0d addr=%0d want 0/2/2", tmo, last, last_addr);
      else n_pass++;
      n_total++;
      if (mismatch !== MIS_EXP) $display("FAIL mis_sticky: got %b want %b", mismatch, MIS_EXP);
      else n_pass++;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_enq3();
      test_deq_empty();
      test_full();
      test_backpressure();
      test_reset_issue();
      test_random();
      test_mismatch();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/queue_op_ctl.md
QUEUE_OP_CTL -- requirements
Module: queue_op_ctl

Interface
REQ-001 Parameter DEPTH, default 16, maximum legal value of last_addr (queue capacity).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  operation request valid.
REQ-005 req_op  input  2  01 = enqueue, 10 = dequeue, 00/11 = illegal.
REQ-006 req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-007 enq, deq, last_done  output  1 each  command strobes to the last-address counter.
REQ-008 last_addr  output  32  controller's committed last address, presented to the counter.
REQ-009 new_last  input  32  registered counter result, valid the cycle after last_done.
REQ-010 rsp_valid  output  1  response valid; held until rsp_ready.
REQ-011 rsp_ready  input  1  response accepted when rsp_valid & rsp_ready.
REQ-012 rsp_err  output  1  request rejected (full, empty or illegal op).
REQ-013 rsp_last  output  32  last address after the operation.
REQ-014 mismatch  output  1  sticky counter-mismatch flag (see Configuration).

Function
REQ-015 FSM states IDLE, ISSUE, RESP; encoding free.
REQ-016 IDLE: on accept of legal enq with last_addr < DEPTH, or legal deq with last_addr > 0, latch op, go ISSUE.
REQ-017 IDLE: on accept of enq at last_addr == DEPTH, deq at last_addr == 0, or op 00/11, set rsp_err = 1, go RESP directly; no strobes issued.
REQ-018 ISSUE lasts exactly one cycle: last_done = 1, enq or deq = 1 per latched op, last_addr stable; then RESP.
REQ-019 enq, deq, last_done are 0 in every state except ISSUE; enq and deq never high together.
REQ-020 RESP after ISSUE: rsp_valid = 1, rsp_err = 0, rsp_last = new_last.
REQ-021 RESP after reject: rsp_valid = 1, rsp_err = 1, rsp_last = last_addr (unchanged).
REQ-022 RESP exit on rsp_valid & rsp_ready: last_addr <= rsp_last (only when rsp_err = 0), go IDLE.
REQ-023 Latency: accept in cycle N, strobes in N+1, rsp_valid in N+2 for legal ops; rsp_valid in N+1 for rejects.
REQ-024 rsp_valid, rsp_err, rsp_last stable while rsp_ready low; backpressure indefinite.
REQ-025 One operation outstanding at a time; req_valid ignored outside IDLE.
REQ-026 last_addr arithmetic unsigned 32-bit; bounds REQ-016/017 guarantee no wrap at 0 or DEPTH.

Reset
REQ-027 rst low forces IDLE immediately, independent of clk, including mid-ISSUE or mid-RESP.
REQ-028 Reset values: last_addr 0, enq/deq/last_done 0, rsp_valid 0, rsp_err 0, rsp_last 0, mismatch 0, req_ready 0 while rst low, 1 first cycle after release.
REQ-029 An operation interrupted by reset is discarded; no response is produced for it.

Configuration
REQ-030 Macro LAST_CHECK_EN defined: in RESP after ISSUE, new_last compared with last_addr+1 (enq) or last_addr-1 (deq); inequality sets mismatch, cleared only by reset.
REQ-031 Macro LAST_CHECK_EN undefined: no comparator; mismatch tied 0; all other behaviour identical.

Verification
REQ-032 Reset, 3 enq with rsp_ready = 1 -> each strobe cycle enq = last_done = 1; rsp_last 1, 2, 3; last_addr = 3.
REQ-033 From last_addr = 0, deq -> rsp_err = 1, rsp_last = 0, no strobes, response one cycle after accept.
REQ-034 DEPTH = 16, 16 enq then 17th enq -> 17th rsp_err = 1, rsp_last = 16; then deq -> rsp_last = 15.
REQ-035 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_last held, req_ready 0, no extra strobes.
REQ-036 rst low during ISSUE -> all outputs 0 same time step, last_addr = 0, no response after release.
REQ-037 With LAST_CHECK_EN, model returns new_last = last_addr+2 on enq -> mismatch = 1, stays 1 through later correct ops; without macro stays 0.
